// File: rtl/beta_fetch_unit.sv
// Instruction-fetch stage of the unpipelined Beta core: owns PC, runs the IMEM
// handshake, holds the instruction register and forms the next PC from PCSEL.
module beta_fetch_unit #(
   parameter logic [31:0] RESET_ADDR    = 32'h8000_0000,
   parameter logic [31:0] ILLOP_ADDR    = 32'h8000_0004,
   parameter logic [31:0] XADR_ADDR     = 32'h8000_0008,
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [2:0]  i_pcsel,
   input  logic [31:0] i_jt,
   input  logic        i_advance,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_imem_ack,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   output logic [31:0] o_instruction,
   output logic        o_instr_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_inc,
   output logic        o_supervisor,
   output logic        o_fetch_err
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 8;

   localparam logic [W-1:0] RST_PC   = RESET_ADDR & ~32'h3;
   localparam logic [W-1:0] ILLOP_PC = ILLOP_ADDR & ~32'h3;
   localparam logic [W-1:0] XADR_PC  = XADR_ADDR & ~32'h3;
   localparam logic [CW-1:0] TMO_LAST = CW'(FETCH_TIMEOUT - 1);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_ISSUE} state_t;

   state_t          r_state;
   logic [W-1:0]    r_pc;
   logic [W-1:0]    r_pc_inc;
   logic [W-1:0]    r_instr;
   logic            r_instr_valid;
   logic            r_imem_req;
   logic            r_fetch_err;
   logic [CW-1:0]   r_cnt;

   logic [30:0]     w_branch_off;
   logic [W-1:0]    w_pc_sel;
   logic [W-1:0]    w_pc_next;
   logic            w_timeout;

   // Supervisor bit is carried separately so +4 and branch offsets wrap in [30:0]
   function automatic logic [W-1:0] f_inc(input logic [W-1:0] pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

   // Next-PC selection for the ADVANCE edge
   always_comb begin
      w_branch_off = {{13{r_instr[15]}}, r_instr[15:0], 2'b00};
      w_pc_sel     = ILLOP_PC;
      case (i_pcsel)
         3'd0:    w_pc_sel = r_pc_inc;
         3'd1:    w_pc_sel = {r_pc[31], r_pc_inc[30:0] + w_branch_off};
         3'd2:    w_pc_sel = {r_pc[31] & i_jt[31], i_jt[30:0]};
         3'd4:    w_pc_sel = XADR_PC;
         default: w_pc_sel = ILLOP_PC;
      endcase
      w_pc_next = w_pc_sel & ~32'h3;
      w_timeout = (r_state == S_FETCH) && !i_imem_ack && (r_cnt == TMO_LAST);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_BOOT;
         r_pc          <= RST_PC;
         r_pc_inc      <= f_inc(RST_PC);
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_imem_req    <= 1'b0;
         r_fetch_err   <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_fetch_err <= 1'b0;
         case (r_state)
            S_BOOT: begin
               r_state    <= S_FETCH;
               r_imem_req <= 1'b1;
               r_cnt      <= '0;
            end
            S_FETCH: begin
               if (i_imem_ack) begin
                  r_instr       <= i_imem_rdata;
                  r_cnt         <= '0;
                  r_imem_req    <= 1'b0;
                  r_instr_valid <= 1'b1;
                  r_state       <= S_ISSUE;
               end else if (w_timeout) begin
                  r_pc        <= ILLOP_PC;
                  r_pc_inc    <= f_inc(ILLOP_PC);
                  r_fetch_err <= 1'b1;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_ISSUE: begin
               if (i_advance) begin
                  r_pc          <= w_pc_next;
                  r_pc_inc      <= f_inc(w_pc_next);
                  r_instr_valid <= 1'b0;
                  r_imem_req    <= 1'b1;
                  r_state       <= S_FETCH;
               end
            end
            default: begin
               r_state       <= S_BOOT;
               r_imem_req    <= 1'b0;
               r_instr_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_imem_req    = r_imem_req;
   assign o_imem_addr   = r_pc;
   assign o_instruction = r_instr;
   assign o_instr_valid = r_instr_valid;
   assign o_pc          = r_pc;
   assign o_pc_inc      = r_pc_inc;
   assign o_supervisor  = r_pc[31];
   assign o_fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Directed bench for beta_fetch_unit: a cycle model of the fetch/issue rules is
// compared on every falling edge, plus literal checks at the interesting points.
module tb_beta_fetch_unit;

   localparam logic [31:0] RESET_ADDR = 32'h8000_0000;
   localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
   localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;
   localparam int          TMO        = 15;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [2:0]  pcsel = 3'd0;
   logic [31:0] jt    = 32'h0;
   logic        advance = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic        ack   = 1'b0;

   logic        imem_req, instr_valid, supervisor, fetch_err;
   logic [31:0] imem_addr, instruction, pc, pc_inc;

   int n_checks = 0;
   int n_errors = 0;

   beta_fetch_unit #(
      .RESET_ADDR(RESET_ADDR), .ILLOP_ADDR(ILLOP_ADDR),
      .XADR_ADDR(XADR_ADDR), .FETCH_TIMEOUT(TMO)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pcsel(pcsel), .i_jt(jt),
      .i_advance(advance), .i_imem_rdata(rdata), .i_imem_ack(ack),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr), .o_instruction(instruction),
      .o_instr_valid(instr_valid), .o_pc(pc), .o_pc_inc(pc_inc),
      .o_supervisor(supervisor), .o_fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phases described by flags, PC arithmetic done on plain 32-bit values
   logic [31:0] m_pc = RESET_ADDR, m_instr = 32'h0;
   logic        m_valid = 1'b0, m_req = 1'b0, m_err = 1'b0, m_boot = 1'b1;
   int          m_wait = 0;

   function automatic logic [31:0] plus4(input logic [31:0] p);
      return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
   endfunction

   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                              input logic [2:0] sel, input logic [31:0] j);
      logic [31:0] off;
      off = {{14{ins[15]}}, ins[15:0], 2'b00};
      case (sel)
         3'd0:    return plus4(p);
         3'd1:    return (p & 32'h8000_0000) | ((p + 32'd4 + off) & 32'h7FFF_FFFC);
         3'd2:    return ((p & j) & 32'h8000_0000) | (j & 32'h7FFF_FFFC);
         3'd4:    return XADR_ADDR;
         default: return ILLOP_ADDR;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = RESET_ADDR; m_instr = 32'h0; m_valid = 1'b0; m_req = 1'b0;
         m_err = 1'b0; m_boot = 1'b1; m_wait = 0;
      end else begin
         m_err = 1'b0;
         if (m_boot) begin
            m_boot = 1'b0; m_req = 1'b1; m_wait = 0;
         end else if (m_req) begin
            m_wait++;
            if (ack) begin
               m_instr = rdata; m_req = 1'b0; m_valid = 1'b1; m_wait = 0;
            end else if (m_wait == TMO) begin
               m_pc = ILLOP_ADDR; m_err = 1'b1; m_wait = 0;
            end
         end else if (m_valid && advance) begin
            m_pc = model_next(m_pc, m_instr, pcsel, jt);
            m_valid = 1'b0; m_req = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_req", 32'(imem_req), 32'(m_req));
      chk("m_addr", imem_addr, m_pc);
      chk("m_instr", instruction, m_instr);
      chk("m_valid", 32'(instr_valid), 32'(m_valid));
      chk("m_pc", pc, m_pc);
      chk("m_pc_inc", pc_inc, plus4(m_pc));
      chk("m_sup", 32'(supervisor), 32'(m_pc[31]));
      chk("m_err", 32'(fetch_err), 32'(m_err));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] word, input int delay);
      if (!imem_req) chk("fetch_entry_req", 32'(imem_req), 32'd1);
      repeat (delay) tick();
      ack = 1'b1; rdata = word;
      tick();
      ack = 1'b0; rdata = $urandom;
   endtask

   task automatic issue(input logic [2:0] sel, input logic [31:0] j);
      pcsel = sel; jt = j; advance = 1'b1;
      tick();
      advance = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      tick();
      chk("rst_pc", pc, 32'h8000_0000);
      chk("rst_pc_inc", pc_inc, 32'h8000_0004);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      chk("rst_sup", 32'(supervisor), 32'd1);
      tick();
      rst_n = 1'b1;
      chk("boot_idle_req", 32'(imem_req), 32'd0);
      tick();
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h8000_0000);
      fetch(32'h8000_0000, 2);
      chk("t1_instr", instruction, 32'h8000_0000);
      chk("t1_valid", 32'(instr_valid), 32'd1);

      // ACK outside the fetch phase must not disturb the instruction register
      ack = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      ack = 1'b0;
      chk("ack_in_issue", instruction, 32'h8000_0000);

      issue(3'd0, 32'h0); fetch(32'h0000_1111, 0);
      issue(3'd0, 32'h0); fetch(32'h0000_2222, 1);
      issue(3'd0, 32'h0); fetch(32'h0000_3333, 0);
      issue(3'd0, 32'h0); fetch(32'h0000_FFFE, 0);
      chk("t2_pc", pc, 32'h8000_0010);
      chk("t2_pc_inc", pc_inc, 32'h8000_0014);
      issue(3'd1, 32'h0);
      chk("t2_branch_addr", imem_addr, 32'h8000_000C);

      fetch(32'h1234_5678, 0); issue(3'd2, 32'h0000_0100);
      chk("t3_pc_setup", pc, 32'h0000_0100);
      fetch(32'h0, 0); issue(3'd2, 32'h8000_1003);
      chk("t3_jmp_pc", pc, 32'h0000_1000);
      chk("t3_sup", 32'(supervisor), 32'd0);

      fetch(32'h0, 0); issue(3'd2, 32'h0000_0040);
      fetch(32'h0, 0); issue(3'd4, 32'h0);
      chk("t4_irq_pc", pc, 32'h8000_0008);
      chk("t4_irq_sup", 32'(supervisor), 32'd1);
      fetch(32'h0, 0); issue(3'd2, 32'h0000_0040);
      fetch(32'h0, 0); issue(3'd6, 32'h0);
      chk("t4_illop_pc", pc, 32'h8000_0004);

      // [30:0] wrap in user and supervisor mode
      fetch(32'h0, 0); issue(3'd2, 32'h7FFF_FFFC);
      chk("wrap_user_inc", pc_inc, 32'h0000_0000);
      fetch(32'h0, 0); issue(3'd0, 32'h0);
      chk("wrap_user_pc", pc, 32'h0000_0000);
      fetch(32'h0, 0); issue(3'd4, 32'h0);
      fetch(32'h0, 0); issue(3'd2, 32'hFFFF_FFFF);
      chk("sup_jmp_align", pc, 32'hFFFF_FFFC);
      chk("wrap_sup_inc", pc_inc, 32'h8000_0000);
      fetch(32'h0, 0); issue(3'd0, 32'h0);
      chk("wrap_sup_pc", pc, 32'h8000_0000);

      // Timeout, with ADVANCE asserted during the wait (must be ignored)
      advance = 1'b1; pcsel = 3'd4;
      repeat (TMO - 1) tick();
      chk("t5_no_err_early", 32'(fetch_err), 32'd0);
      tick();
      advance = 1'b0;
      chk("t5_err", 32'(fetch_err), 32'd1);
      chk("t5_addr", imem_addr, 32'h8000_0004);
      tick();
      chk("t5_err_pulse", 32'(fetch_err), 32'd0);
      repeat (TMO - 2) tick();
      ack = 1'b1; rdata = 32'hCAFE_0001;
      tick();
      ack = 1'b0;
      chk("t5_ack_wins_err", 32'(fetch_err), 32'd0);
      chk("t5_ack_wins_instr", instruction, 32'hCAFE_0001);
      chk("t5_ack_wins_valid", 32'(instr_valid), 32'd1);

      // Reset during fetch, with ACK/ADVANCE held active
      issue(3'd0, 32'h0);
      tick();
      #2 rst_n = 1'b0; advance = 1'b1; ack = 1'b1;
      #1;
      chk("t6_fetch_req", 32'(imem_req), 32'd0);
      chk("t6_fetch_pc", pc, 32'h8000_0000);
      tick(); tick();
      chk("t6_hold_valid", 32'(instr_valid), 32'd0);
      chk("t6_hold_instr", instruction, 32'h0);
      advance = 1'b0; ack = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("t6_refetch_addr", imem_addr, 32'h8000_0000);
      fetch(32'h0BAD_F00D, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_issue_valid", 32'(instr_valid), 32'd0);
      chk("t6_issue_pc", pc, 32'h8000_0000);
      tick();
      rst_n = 1'b1;
      tick();
      fetch(32'h0000_0042, 3);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
